// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg : shared constants and byte-extraction helper for the AES result path
// Revision: 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] FINAL_RCON_DEFAULT = 8'h36;
    localparam int         BLOCK_W            = 128;
    localparam int         BYTES_PER_BLOCK    = 16;
    localparam int         IDX_W              = $clog2(BYTES_PER_BLOCK);

    // Byte 0 is the most significant byte of the block.
    function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                              input logic [IDX_W-1:0]   idx);
        return blk[BLOCK_W - 1 - 8 * int'(idx) -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_block_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_block_fifo : DEPTH x W synchronous block FIFO, write accepted when full
//                  only if a read happens at the same edge
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_block_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       rd_en_i,
    output logic [W-1:0]               rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/aes_result_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_result_serializer : captures final-round AES states into a block FIFO
//                         and drains them as a byte-serial valid/ready stream
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_result_serializer
    import aes_pkg::*;
#(
    parameter logic [7:0] FINAL_RCON = FINAL_RCON_DEFAULT,
    parameter int         DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic [BLOCK_W-1:0]        in_state,
    input  logic                      in_empty,
    input  logic [7:0]                in_rcon,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic [7:0]                drop_cnt
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_SEND  = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

    logic [0:0]         state_q, state_d;
    logic [BLOCK_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               overflow_q;
    logic [7:0]         drop_cnt_q;

    logic               capture, push, pop, drop, last_hs;
    logic               fifo_full, fifo_empty;
    logic [BLOCK_W-1:0] fifo_rd_data;

    assign capture = !in_empty && (in_rcon == FINAL_RCON);
    assign last_hs = (state_q == ST_SEND) && out_ready && (idx_q == LAST_IDX);
    assign pop     = !fifo_empty && ((state_q == ST_IDLE) || last_hs);
    // The round pipeline cannot stall, so a block with nowhere to go is lost.
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && !push;

    aes_block_fifo #(
        .DEPTH (DEPTH),
        .W     (BLOCK_W)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .wr_en_i   (push),
        .wr_data_i (in_state),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        if (pop) begin
            shift_d = fifo_rd_data;
            idx_d   = '0;
            state_d = ST_SEND;
        end else if ((state_q == ST_SEND) && out_ready) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end else begin
                shift_d = shift_q << 8;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign out_valid = (state_q == ST_SEND);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_data  = out_valid ? block_byte(shift_q, '0) : 8'h00;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_result_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_result_serializer : directed self-checking bench for the serializer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_aes_result_serializer;

    logic         clock = 1'b0;
    logic         rst_n;
    logic [127:0] in_state;
    logic         in_empty;
    logic [7:0]   in_rcon;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [2:0]   fifo_count;
    logic         overflow;
    logic         ovf_clr;
    logic [7:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    aes_result_serializer #(
        .FINAL_RCON (8'h36),
        .DEPTH      (4)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_state   (in_state),
        .in_empty   (in_empty),
        .in_rcon    (in_rcon),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_cnt   (drop_cnt)
    );

    always #5 clock = ~clock;

    // Block k carries byte j = {k, j}, so order and origin are visible.
    function automatic logic [127:0] make_blk(input logic [3:0] k);
        logic [127:0] b;
        for (int j = 0; j < 16; j++) b[127 - 8*j -: 8] = {k, 4'(j)};
        return b;
    endfunction

    // One-cycle final-round beat; called just after a falling edge.
    task automatic capture(input logic [127:0] b);
        in_state = b;
        in_empty = 1'b0;
        in_rcon  = 8'h36;
        @(negedge clock);
        in_empty = 1'b1;
        in_rcon  = 8'h00;
    endtask

    // {valid, last, data} compared as one 10-bit word.
    task automatic test_reset;
        rst_n = 1'b0; in_state = '0; in_empty = 1'b1; in_rcon = 8'h00;
        out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({out_valid, out_last, out_data, fifo_count, overflow, drop_cnt} !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h cnt=%0d ovf=%b drop=%0d expected all zero",
                     out_valid, out_last, out_data, fifo_count, overflow, drop_cnt);
        end
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_block;
        logic [7:0] exp [16] = '{8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hdc, 8'h09, 8'hfb,
                                 8'hdc, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6a, 8'h0b, 8'h32};
        out_ready = 1'b1;
        capture(128'h3925841d02dc09fbdc118597196a0b32);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: out_valid=%b one edge after capture, expected 0", out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, (i == 15), exp[i]}) begin
                errors++;
                $display("FAIL single_byte[%0d]: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                         i, out_valid, out_last, out_data, (i == 15), exp[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_idle_after: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, fifo_count);
        end
    endtask

    task automatic test_filter;
        in_state = make_blk(4'hE);
        in_empty = 1'b0; in_rcon = 8'h1b;
        @(negedge clock);
        in_empty = 1'b1; in_rcon = 8'h36;
        @(negedge clock);
        in_rcon = 8'h00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL filter[%0d]: got v=%b cnt=%0d expected v=0 cnt=0", i, out_valid, fifo_count);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        capture(make_blk(4'h9));
        @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, (i == 15), 4'h9, 4'(i)}) begin
                errors++;
                $display("FAIL bp_byte[%0d]: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                         i, out_valid, out_last, out_data, (i == 15), {4'h9, 4'(i)});
            end
            if (i == 7) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clock);
                    checks++;
                    if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h97}) begin
                        errors++;
                        $display("FAIL bp_stall[%0d]: got v=%b l=%b d=%h expected v=1 l=0 d=97",
                                 s, out_valid, out_last, out_data);
                    end
                end
                out_ready = 1'b1;
            end
            @(negedge clock);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle_after: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        capture(make_blk(4'h1));
        capture(make_blk(4'h2));
        @(negedge clock);
        checks++;
        if (fifo_count !== 3'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_queued: got cnt=%0d v=%b expected cnt=1 v=1", fifo_count, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({out_valid, out_last, out_data} !== {1'b1, (i % 16 == 15), 4'(1 + i / 16), 4'(i % 16)}) begin
                errors++;
                $display("FAIL b2b_byte[%0d]: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                         i, out_valid, out_last, out_data, (i % 16 == 15), {4'(1 + i / 16), 4'(i % 16)});
            end
            @(negedge clock);
        end
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_idle_after: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, fifo_count);
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            capture(make_blk(4'(3 + k)));
            if (k == 4) begin
                checks++;
                if ({fifo_count, overflow, drop_cnt} !== {3'd4, 1'b0, 8'd0}) begin
                    errors++;
                    $display("FAIL ovf_fill: got cnt=%0d ovf=%b drop=%0d expected cnt=4 ovf=0 drop=0",
                             fifo_count, overflow, drop_cnt);
                end
            end
        end
        checks++;
        if ({fifo_count, overflow, drop_cnt} !== {3'd4, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ovf_drop: got cnt=%0d ovf=%b drop=%0d expected cnt=4 ovf=1 drop=1",
                     fifo_count, overflow, drop_cnt);
        end
        ovf_clr = 1'b1;
        capture(make_blk(4'hF));
        checks++;
        if ({overflow, drop_cnt} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL ovf_set_wins: got ovf=%b drop=%0d expected ovf=1 drop=2", overflow, drop_cnt);
        end
        @(negedge clock);
        ovf_clr = 1'b0;
        checks++;
        if ({overflow, drop_cnt, fifo_count} !== {1'b0, 8'd2, 3'd4}) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b drop=%0d cnt=%0d expected ovf=0 drop=2 cnt=4",
                     overflow, drop_cnt, fifo_count);
        end
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h30}) begin
            errors++;
            $display("FAIL ovf_head_hold: got v=%b l=%b d=%h expected v=1 l=0 d=30",
                     out_valid, out_last, out_data);
        end
    endtask

    task automatic test_reset_mid_block;
        out_ready = 1'b1;
        repeat (9) @(negedge clock);
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h39}) begin
            errors++;
            $display("FAIL rst_mid_byte9: got v=%b d=%h expected v=1 d=39", out_valid, out_data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_data, fifo_count, overflow, drop_cnt} !== 22'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%b l=%b d=%h cnt=%0d ovf=%b drop=%0d expected all zero",
                     out_valid, out_last, out_data, fifo_count, overflow, drop_cnt);
        end
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({out_valid, fifo_count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL rst_mid_discard: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, fifo_count);
        end
        capture(make_blk(4'hA));
        @(negedge clock);
        checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'hA0}) begin
            errors++;
            $display("FAIL rst_mid_restart: got v=%b l=%b d=%h expected v=1 l=0 d=a0",
                     out_valid, out_last, out_data);
        end
        repeat (16) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_filter();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
